// File: rtl/stream_pack_16to64_if.sv
// Handshake bundle for the 16-to-64 packer: input word stream,
// flush request, output beat stream and packet counter.
interface stream_pack_16to64_if;
  logic [15:0] in_tdata;
  logic        in_tvalid;
  logic        in_tready;
  logic        flush;
  logic [63:0] out_tdata;
  logic [7:0]  out_tkeep;
  logic        out_tlast;
  logic        out_tvalid;
  logic        out_tready;
  logic [15:0] pkt_cnt;

  modport master (
    output in_tdata, in_tvalid, flush, out_tready,
    input  in_tready, out_tdata, out_tkeep, out_tlast,
    input  out_tvalid, pkt_cnt
  );

  modport slave (
    input  in_tdata, in_tvalid, flush, out_tready,
    output in_tready, out_tdata, out_tkeep, out_tlast,
    output out_tvalid, pkt_cnt
  );
endinterface

// File: rtl/stream_pack_16to64.sv
// Packs four 16-bit words into 64-bit beats, frames packets with tlast,
// supports early flush with byte-masked partial beats, 2-entry out buffer.
module stream_pack_16to64 #(
  parameter int PKT_BEATS = 8
) (
  input logic aclk,
  input logic reset_p,
  stream_pack_16to64_if.slave io
);
  localparam logic [7:0] LAST_BEAT = 8'(PKT_BEATS - 1);

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic [1:0]  lane;
  logic [47:0] acc;
  logic [7:0]  beat_cnt;
  logic        flush_pend;
  beat_t       mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  buf_count;
  logic [15:0] pkt_q;

  logic        ready;
  logic        take;
  logic        pop;
  logic        fp;
  logic        push;
  logic [1:0]  lane_nxt;
  logic [47:0] acc_nxt;
  logic [7:0]  part_keep;
  beat_t       beat;

  assign ready = (buf_count != 2'd2);
  assign take  = io.in_tvalid & ready;
  assign pop   = (buf_count != 2'd0) & io.out_tready;
  assign fp    = flush_pend | io.flush;

  always_comb begin
    part_keep = 8'h00;
    case (lane_nxt)
      2'd1:    part_keep = 8'h03;
      2'd2:    part_keep = 8'h0F;
      2'd3:    part_keep = 8'h3F;
      default: part_keep = 8'h00;
    endcase
  end

  // acc is cleared on every push, so unused partial slots read as zero
  always_comb begin
    acc_nxt  = acc;
    lane_nxt = lane;
    push     = 1'b0;
    beat     = '0;
    if (take && lane != 2'd3) begin
      acc_nxt[16*lane +: 16] = io.in_tdata;
      lane_nxt = lane + 2'd1;
    end
    if (take && lane == 2'd3) begin
      push      = 1'b1;
      beat.data = {io.in_tdata, acc};
      beat.keep = 8'hFF;
      beat.last = fp | (beat_cnt == LAST_BEAT);
    end else if (ready && fp && lane_nxt != 2'd0) begin
      push      = 1'b1;
      beat.data = {16'h0000, acc_nxt};
      beat.keep = part_keep;
      beat.last = 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge reset_p) begin
    if (reset_p) begin
      lane       <= 2'd0;
      acc        <= '0;
      beat_cnt   <= 8'd0;
      flush_pend <= 1'b0;
      mem[0]     <= '0;
      mem[1]     <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      buf_count  <= 2'd0;
      pkt_q      <= 16'd0;
    end else begin
      flush_pend <= ready ? 1'b0 : fp;
      if (push) begin
        lane        <= 2'd0;
        acc         <= '0;
        beat_cnt    <= beat.last ? 8'd0 : beat_cnt + 8'd1;
        mem[wr_ptr] <= beat;
        wr_ptr      <= ~wr_ptr;
      end else begin
        lane <= lane_nxt;
        acc  <= acc_nxt;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        if (mem[rd_ptr].last) pkt_q <= pkt_q + 16'd1;
      end
      case ({push, pop})
        2'b10:   buf_count <= buf_count + 2'd1;
        2'b01:   buf_count <= buf_count - 2'd1;
        default: buf_count <= buf_count;
      endcase
    end
  end

  assign io.in_tready  = ready;
  assign io.out_tvalid = (buf_count != 2'd0);
  assign io.out_tdata  = mem[rd_ptr].data;
  assign io.out_tkeep  = mem[rd_ptr].keep;
  assign io.out_tlast  = mem[rd_ptr].last;
  assign io.pkt_cnt    = pkt_q;
endmodule

// File: tb/tb_stream_pack_16to64.sv
// Randomized and directed bench for stream_pack_16to64 against a
// queue-based packing model.
module tb_stream_pack_16to64;
  localparam int PB = 8;

  logic aclk = 1'b0;
  logic reset_p;
  always #5 aclk = ~aclk;

  stream_pack_16to64_if bus ();

  stream_pack_16to64 #(.PKT_BEATS(PB)) dut (
    .aclk(aclk),
    .reset_p(reset_p),
    .io(bus)
  );

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } bt_t;

  int checks = 0;
  int failures = 0;

  bt_t         exp_q[$];
  bt_t         pop_log[$];
  logic [15:0] cur[$];
  int          nb;
  bit          fp;
  logic [15:0] m_pkt;
  bit          stalled;
  logic [63:0] pd;
  logic [7:0]  pk;
  logic        pl;

  // model: advances once per cycle using values stable at the falling edge
  always @(negedge aclk) begin
    if (reset_p) begin
      exp_q.delete();
      pop_log.delete();
      cur.delete();
      nb = 0;
      fp = 0;
      m_pkt = 16'd0;
      stalled = 0;
    end else begin
      bit rdy;
      bt_t b;
      rdy = (exp_q.size() != 2);
      checks++;
      if (bus.out_tvalid !== (exp_q.size() != 0)) begin
        failures++;
        $display("FAIL out_tvalid got=%0b exp=%0b t=%0t",
                 bus.out_tvalid, exp_q.size() != 0, $time);
      end
      checks++;
      if (bus.in_tready !== rdy) begin
        failures++;
        $display("FAIL in_tready got=%0b exp=%0b t=%0t",
                 bus.in_tready, rdy, $time);
      end
      checks++;
      if (bus.pkt_cnt !== m_pkt) begin
        failures++;
        $display("FAIL pkt_cnt got=%h exp=%h t=%0t",
                 bus.pkt_cnt, m_pkt, $time);
      end
      if (stalled) begin
        checks++;
        if (bus.out_tdata !== pd || bus.out_tkeep !== pk ||
            bus.out_tlast !== pl) begin
          failures++;
          $display("FAIL stall_stable got=%h/%h/%b exp=%h/%h/%b",
                   bus.out_tdata, bus.out_tkeep, bus.out_tlast, pd, pk, pl);
        end
      end
      if (bus.out_tvalid && bus.out_tready && exp_q.size() > 0) begin
        b = exp_q.pop_front();
        checks++;
        if (bus.out_tdata !== b.d || bus.out_tkeep !== b.k ||
            bus.out_tlast !== b.l) begin
          failures++;
          $display("FAIL beat got=%h/%h/%b exp=%h/%h/%b t=%0t",
                   bus.out_tdata, bus.out_tkeep, bus.out_tlast,
                   b.d, b.k, b.l, $time);
        end
        pop_log.push_back('{bus.out_tdata, bus.out_tkeep, bus.out_tlast});
        if (b.l) m_pkt = m_pkt + 16'd1;
      end
      stalled = bus.out_tvalid && !bus.out_tready;
      pd = bus.out_tdata;
      pk = bus.out_tkeep;
      pl = bus.out_tlast;
      fp = fp | bus.flush;
      if (rdy) begin
        if (bus.in_tvalid) cur.push_back(bus.in_tdata);
        if (cur.size() == 4) begin
          b.d = {cur[3], cur[2], cur[1], cur[0]};
          b.k = 8'hFF;
          b.l = fp || (nb == PB - 1);
          nb = b.l ? 0 : nb + 1;
          exp_q.push_back(b);
          cur.delete();
        end else if (fp && cur.size() > 0) begin
          b.d = '0;
          for (int i = 0; i < cur.size(); i++) b.d[16*i +: 16] = cur[i];
          b.k = 8'((1 << (2 * cur.size())) - 1);
          b.l = 1'b1;
          nb = 0;
          exp_q.push_back(b);
          cur.delete();
        end
        fp = 0;
      end
    end
  end

  task automatic do_reset();
    bus.in_tvalid = 0;
    bus.in_tdata = 0;
    bus.flush = 0;
    bus.out_tready = 0;
    reset_p = 1;
    repeat (2) @(posedge aclk);
    #1 reset_p = 0;
  endtask

  task automatic send_word(input logic [15:0] w, input logic fl);
    bit ok;
    ok = 0;
    bus.in_tdata = w;
    bus.in_tvalid = 1;
    bus.flush = fl;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge aclk);
      ok = bus.in_tready;
      @(posedge aclk);
      #1;
    end
    bus.in_tvalid = 0;
    bus.flush = 0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_word timeout word=%h", w);
    end
  endtask

  task automatic pulse_flush();
    bus.flush = 1;
    @(posedge aclk);
    #1 bus.flush = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_tready = 1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge aclk);
      #1 n++;
    end
    repeat (2) @(posedge aclk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain timeout left=%0d need=0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.in_tready !== 1'b1 || bus.out_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs got=%b/%b exp=1/0", bus.in_tready, bus.out_tvalid);
    end
    checks++;
    if (bus.out_tdata !== 64'd0 || bus.out_tkeep !== 8'd0 ||
        bus.out_tlast !== 1'b0) begin
      failures++;
      $display("FAIL reset_out got=%h/%h/%b exp=0/0/0",
               bus.out_tdata, bus.out_tkeep, bus.out_tlast);
    end
    checks++;
    if (bus.pkt_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_pkt got=%h exp=0", bus.pkt_cnt);
    end
  endtask

  task automatic test_streaming();
    do_reset();
    bus.out_tready = 1;
    for (int w = 0; w < 32; w++) send_word(16'(w), 1'b0);
    drain();
    checks++;
    if (pop_log.size() != 8 || pop_log[0].d !== 64'h0003_0002_0001_0000 ||
        pop_log[0].k !== 8'hFF) begin
      failures++;
      $display("FAIL stream_first got=%0d/%h exp=8/0003000200010000",
               pop_log.size(), pop_log[0].d);
    end
    checks++;
    if (pop_log[6].l !== 1'b0 || pop_log[7].l !== 1'b1 ||
        bus.pkt_cnt !== 16'd1) begin
      failures++;
      $display("FAIL stream_last got=%b%b/%h exp=01/0001",
               pop_log[6].l, pop_log[7].l, bus.pkt_cnt);
    end
  endtask

  task automatic test_early_flush();
    do_reset();
    bus.out_tready = 1;
    for (int w = 0; w < 6; w++) send_word(16'hA0 + 16'(w), 1'b0);
    pulse_flush();
    drain();
    checks++;
    if (pop_log.size() != 2 || pop_log[0].l !== 1'b0 ||
        pop_log[1].d !== 64'h0000_0000_00A5_00A4 ||
        pop_log[1].k !== 8'h0F || pop_log[1].l !== 1'b1) begin
      failures++;
      $display("FAIL early_flush got=%0d/%h/%h/%b exp=2/00A500A4/0F/1",
               pop_log.size(), pop_log[1].d, pop_log[1].k, pop_log[1].l);
    end
    for (int w = 0; w < 32; w++) send_word(16'($urandom), 1'b0);
    drain();
    checks++;
    if (pop_log.size() != 10 || pop_log[8].l !== 1'b0 ||
        pop_log[9].l !== 1'b1) begin
      failures++;
      $display("FAIL flush_restart got=%0d/%b%b exp=10/01",
               pop_log.size(), pop_log[8].l, pop_log[9].l);
    end
  endtask

  task automatic test_flush_coincident();
    do_reset();
    bus.out_tready = 1;
    for (int w = 0; w < 3; w++) send_word(16'h50 + 16'(w), 1'b0);
    send_word(16'h53, 1'b1);
    drain();
    checks++;
    if (pop_log.size() != 1 || pop_log[0].l !== 1'b1 ||
        pop_log[0].k !== 8'hFF) begin
      failures++;
      $display("FAIL flush_coinc got=%0d/%b/%h exp=1/1/FF",
               pop_log.size(), pop_log[0].l, pop_log[0].k);
    end
    pulse_flush();
    drain();
    checks++;
    if (pop_log.size() != 1 || bus.pkt_cnt !== 16'd1) begin
      failures++;
      $display("FAIL flush_empty got=%0d/%h exp=1/0001",
               pop_log.size(), bus.pkt_cnt);
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    bus.out_tready = 0;
    for (int w = 0; w < 8; w++) send_word(16'(w), 1'b0);
    bus.in_tdata = 16'd8;
    bus.in_tvalid = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      checks++;
      if (bus.in_tready !== 1'b0 || bus.out_tvalid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold got=%b/%b exp=0/1",
                 bus.in_tready, bus.out_tvalid);
      end
      @(posedge aclk);
      #1;
    end
    bus.out_tready = 1;
    for (int w = 8; w < 12; w++) send_word(16'(w), 1'b0);
    drain();
    checks++;
    if (pop_log.size() != 3 ||
        pop_log[2].d !== 64'h000B_000A_0009_0008) begin
      failures++;
      $display("FAIL bp_release got=%0d/%h exp=3/000B000A00090008",
               pop_log.size(), pop_log[2].d);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.out_tready = 0;
    for (int w = 0; w < 6; w++) send_word(16'h10 + 16'(w), 1'b0);
    #2 reset_p = 1;
    #1;
    checks++;
    if (bus.out_tvalid !== 1'b0 || bus.in_tready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset got=%b/%b exp=0/1",
               bus.out_tvalid, bus.in_tready);
    end
    @(posedge aclk);
    #1 reset_p = 0;
    bus.out_tready = 1;
    for (int w = 0; w < 4; w++) send_word(16'hB0 + 16'(w), 1'b0);
    drain();
    checks++;
    if (pop_log.size() != 1 ||
        pop_log[0].d !== 64'h00B3_00B2_00B1_00B0) begin
      failures++;
      $display("FAIL post_reset got=%0d/%h exp=1/00B300B200B100B0",
               pop_log.size(), pop_log[0].d);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.out_tready = 1;
    force dut.pkt_q = 16'hFFFE;
    m_pkt = 16'hFFFE;
    #1 release dut.pkt_q;
    for (int p = 0; p < 3; p++) begin
      for (int w = 0; w < 3; w++) send_word(16'($urandom), 1'b0);
      send_word(16'($urandom), 1'b1);
    end
    drain();
    checks++;
    if (bus.pkt_cnt !== 16'h0001) begin
      failures++;
      $display("FAIL pkt_wrap got=%h exp=0001", bus.pkt_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bus.in_tvalid = ($urandom_range(0, 9) < 7);
      bus.in_tdata = 16'($urandom);
      bus.flush = ($urandom_range(0, 19) == 0);
      bus.out_tready = ($urandom_range(0, 9) < 6);
      @(posedge aclk);
      #1;
    end
    bus.in_tvalid = 0;
    bus.flush = 0;
    drain();
    checks++;
    if (pop_log.size() < 100) begin
      failures++;
      $display("FAIL random_volume got=%0d exp>=100", pop_log.size());
    end
  endtask

  initial begin
    reset_p = 1;
    test_reset();
    test_streaming();
    test_early_flush();
    test_flush_coincident();
    test_back_pressure();
    test_async_reset();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
